// File: rtl/ex_stage_alu_if.sv
// EX-stage operand/result bundle between the forwarding logic, the ALU and the MEM stage.
interface ex_stage_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_in;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       rd_in;
    logic             wb_en_in;
    logic [WIDTH-1:0] result_DM;
    logic [4:0]       rd_DM;
    logic             valid_DM;
    logic             flag_E;
    logic             flag_GT;
    logic             stall;

    modport master (
        output valid_in, aluop, A, B, rd_in, wb_en_in,
        input  result_DM, rd_DM, valid_DM, flag_E, flag_GT, stall
    );

    modport slave (
        input  valid_in, aluop, A, B, rd_in, wb_en_in,
        output result_DM, rd_DM, valid_DM, flag_E, flag_GT, stall
    );
endinterface

// File: rtl/ex_stage_alu.sv
// SimpleRISC execute stage: single-cycle ALU, iterative signed divider and EX/MEM register.
module ex_stage_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic           clk,
    input logic           rst,
    ex_stage_alu_if.slave bus
);
    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
    localparam int unsigned ShW  = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dzero_q, dzero_d;
    logic             mod_q, mod_d;
    logic [4:0]       rd_hold_q, rd_hold_d;
    logic             wb_hold_q, wb_hold_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             valid_q, valid_d;
    logic             flag_e_q, flag_e_d;
    logic             flag_gt_q, flag_gt_d;
    logic             stall_c;

    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial, trial_sub;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             is_div_op;

    assign shamt     = bus.B[ShW-1:0];
    assign a_abs     = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs     = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign is_div_op = (bus.aluop == 4'd3) || (bus.aluop == 4'd4);

    always_comb begin
        alu_res = '0;
        case (bus.aluop)
            4'd0:    alu_res = bus.A + bus.B;
            4'd1:    alu_res = bus.A - bus.B;
            4'd2:    alu_res = bus.A * bus.B;
            4'd6:    alu_res = bus.A & bus.B;
            4'd7:    alu_res = bus.A | bus.B;
            4'd8:    alu_res = ~bus.B;
            4'd9:    alu_res = bus.B;
            4'd10:   alu_res = bus.A << shamt;
            4'd11:   alu_res = bus.A >> shamt;
            4'd12:   alu_res = $unsigned($signed(bus.A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder.
    assign trial     = {rem_q, quot_q[WIDTH-1]};
    assign trial_sub = trial - {1'b0, dvsr_q};

    // A zero divisor leaves the all-ones quotient untouched; the remainder fix-up yields A.
    assign q_fix = (q_neg_q && !dzero_q) ? -quot_q : quot_q;
    assign r_fix = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dzero_d   = dzero_q;
        mod_d     = mod_q;
        rd_hold_d = rd_hold_q;
        wb_hold_d = wb_hold_q;
        result_d  = '0;
        rd_d      = '0;
        valid_d   = 1'b0;
        flag_e_d  = flag_e_q;
        flag_gt_d = flag_gt_q;
        stall_c   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    if (is_div_op) begin
                        stall_c   = 1'b1;
                        rem_d     = '0;
                        quot_d    = a_abs;
                        dvsr_d    = b_abs;
                        q_neg_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        r_neg_d   = bus.A[WIDTH-1];
                        dzero_d   = (bus.B == '0);
                        mod_d     = (bus.aluop == 4'd4);
                        rd_hold_d = bus.rd_in;
                        wb_hold_d = bus.wb_en_in;
                        cnt_d     = '0;
                        state_d   = StDiv;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        if (bus.aluop == 4'd5) begin
                            flag_e_d  = (bus.A == bus.B);
                            flag_gt_d = ($signed(bus.A) > $signed(bus.B));
                        end else if (bus.wb_en_in) begin
                            rd_d = bus.rd_in;
                        end
                    end
                end
            end
            StDiv: begin
                stall_c = 1'b1;
                if (!trial_sub[WIDTH]) begin
                    rem_d  = trial_sub[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                valid_d  = 1'b1;
                result_d = mod_q ? r_fix : q_fix;
                rd_d     = wb_hold_q ? rd_hold_q : 5'd0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dzero_q   <= 1'b0;
            mod_q     <= 1'b0;
            rd_hold_q <= '0;
            wb_hold_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dvsr_q    <= dvsr_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dzero_q   <= dzero_d;
            mod_q     <= mod_d;
            rd_hold_q <= rd_hold_d;
            wb_hold_q <= wb_hold_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
        end
    end

    assign bus.result_DM = result_q;
    assign bus.rd_DM     = rd_q;
    assign bus.valid_DM  = valid_q;
    assign bus.flag_E    = flag_e_q;
    assign bus.flag_GT   = flag_gt_q;
    assign bus.stall     = stall_c;
endmodule

// File: tb/tb_ex_stage_alu.sv
// Randomised and directed bench for ex_stage_alu against a cycle-count reference model.
module tb_ex_stage_alu;
    localparam int DivLat = 34;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ex_stage_alu_if #(.WIDTH(32)) bus ();

    ex_stage_alu #(.WIDTH(32), .DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            4'd4: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            4'd6: return a & b;
            4'd7: return a | b;
            4'd8: return ~b;
            4'd9: return b;
            4'd10: return a << b[4:0];
            4'd11: return a >> b[4:0];
            4'd12: begin
                sr = sa >>> b[4:0];
                return sr;
            end
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: an instruction either retires next edge or, for div/mod, DivLat edges later.
    logic        primed;
    int          cycles_left;
    logic [31:0] pend_res;
    logic [4:0]  pend_rd;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_vld;
    logic        exp_e;
    logic        exp_gt;

    initial begin
        primed      = 1'b0;
        cycles_left = 0;
        exp_e       = 1'b0;
        exp_gt      = 1'b0;
    end

    always @(posedge clk) begin
        exp_res = 32'h0;
        exp_rd  = 5'd0;
        exp_vld = 1'b0;
        if (rst) begin
            exp_e       = 1'b0;
            exp_gt      = 1'b0;
            cycles_left = 0;
            primed      = 1'b1;
        end else if (cycles_left > 0) begin
            cycles_left--;
            if (cycles_left == 0) begin
                exp_vld = 1'b1;
                exp_res = pend_res;
                exp_rd  = pend_rd;
            end
        end else if (bus.valid_in) begin
            if (bus.aluop == 4'd3 || bus.aluop == 4'd4) begin
                pend_res    = ref_res(bus.aluop, bus.A, bus.B);
                pend_rd     = bus.wb_en_in ? bus.rd_in : 5'd0;
                cycles_left = DivLat - 1;
            end else begin
                exp_vld = 1'b1;
                exp_res = ref_res(bus.aluop, bus.A, bus.B);
                if (bus.aluop == 4'd5) begin
                    exp_e  = (bus.A == bus.B);
                    exp_gt = ($signed(bus.A) > $signed(bus.B));
                end else begin
                    exp_rd = bus.wb_en_in ? bus.rd_in : 5'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (primed) begin
            check("result_DM", bus.result_DM, exp_res);
            check("rd_DM", 32'(bus.rd_DM), 32'(exp_rd));
            check("valid_DM", 32'(bus.valid_DM), 32'(exp_vld));
            check("flag_E", 32'(bus.flag_E), 32'(exp_e));
            check("flag_GT", 32'(bus.flag_GT), 32'(exp_gt));
            check("stall", 32'(bus.stall), 32'((cycles_left > 1) ||
                  (cycles_left == 0 && bus.valid_in &&
                   (bus.aluop == 4'd3 || bus.aluop == 4'd4))));
        end
    end

    // Present one instruction at posedge+1; hold it while stalled; return once its result is visible.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wb, output int cycles, output int stalls);
        logic s;
        logic done;
        bus.valid_in = 1'b1;
        bus.aluop    = op;
        bus.A        = a;
        bus.B        = b;
        bus.rd_in    = rd;
        bus.wb_en_in = wb;
        cycles       = 0;
        stalls       = 0;
        done         = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            s = bus.stall;
            if (s) stalls++;
            @(posedge clk);
            #1;
            cycles++;
            if (!s) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: op %0d still stalled after %0d cycles", op, cycles);
        end
        bus.valid_in = 1'b0;
    endtask

    int cyc;
    int stl;

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.aluop    = 4'd0;
        bus.A        = 32'h0;
        bus.B        = 32'h0;
        bus.rd_in    = 5'd0;
        bus.wb_en_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_result", bus.result_DM, 32'h0);
        check("reset_rd", 32'(bus.rd_DM), 32'h0);
        check("reset_valid", 32'(bus.valid_DM), 32'h0);
        check("reset_flags", 32'({bus.flag_E, bus.flag_GT}), 32'h0);
        check("reset_stall", 32'(bus.stall), 32'h0);

        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, cyc, stl);
        check("add_result", bus.result_DM, 32'h8000_0000);
        check("add_rd", 32'(bus.rd_DM), 32'd3);
        check("add_valid", 32'(bus.valid_DM), 32'd1);
        check("add_latency", 32'(cyc), 32'd1);

        issue(4'd5, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, cyc, stl);
        check("cmp1_flags", 32'({bus.flag_E, bus.flag_GT}), 32'b00);
        check("cmp1_rd", 32'(bus.rd_DM), 32'd0);
        issue(4'd5, 32'd5, 32'd5, 5'd7, 1'b1, cyc, stl);
        check("cmp2_flags", 32'({bus.flag_E, bus.flag_GT}), 32'b10);
        issue(4'd0, 32'd1, 32'd2, 5'd1, 1'b1, cyc, stl);
        check("flags_hold", 32'({bus.flag_E, bus.flag_GT}), 32'b10);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, cyc, stl);
        check("div_result", bus.result_DM, 32'hFFFF_FFFD);
        check("div_rd", 32'(bus.rd_DM), 32'd4);
        check("div_latency", 32'(cyc), 32'd34);
        check("div_stalls", 32'(stl), 32'd33);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, cyc, stl);
        check("mod_result", bus.result_DM, 32'hFFFF_FFFF);
        issue(4'd3, 32'd9, 32'd0, 5'd5, 1'b1, cyc, stl);
        check("div0_result", bus.result_DM, 32'hFFFF_FFFF);
        check("div0_latency", 32'(cyc), 32'd34);
        issue(4'd4, 32'd9, 32'd0, 5'd5, 1'b1, cyc, stl);
        check("mod0_result", bus.result_DM, 32'd9);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, cyc, stl);
        check("divovf_result", bus.result_DM, 32'h8000_0000);

        issue(4'd12, 32'h8000_0000, 32'h24, 5'd2, 1'b1, cyc, stl);
        check("asr_result", bus.result_DM, 32'hF800_0000);
        issue(4'd11, 32'h8000_0000, 32'h24, 5'd2, 1'b1, cyc, stl);
        check("lsr_result", bus.result_DM, 32'h0800_0000);
        issue(4'd10, 32'h1, 32'd31, 5'd2, 1'b1, cyc, stl);
        check("lsl_result", bus.result_DM, 32'h8000_0000);

        // Abort a division partway through with reset.
        bus.valid_in = 1'b1;
        bus.aluop    = 4'd3;
        bus.A        = 32'd100;
        bus.B        = 32'd7;
        bus.rd_in    = 5'd9;
        bus.wb_en_in = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_stall", 32'(bus.stall), 32'd0);
        check("abort_valid", 32'(bus.valid_DM), 32'd0);
        issue(4'd0, 32'd20, 32'd22, 5'd8, 1'b1, cyc, stl);
        check("abort_add_result", bus.result_DM, 32'd42);
        check("abort_add_latency", 32'(cyc), 32'd1);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] specials [6];
            specials[0] = 32'h0;
            specials[1] = 32'h1;
            specials[2] = 32'hFFFF_FFFF;
            specials[3] = 32'h8000_0000;
            specials[4] = 32'h7FFF_FFFF;
            specials[5] = 32'd5;
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 2) != 0) begin
                op = 4'($urandom_range(5, 12));
            end
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            issue(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), cyc, stl);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
